// File: rtl/pulse_program_sequencer_if.sv
// Host configuration and pulse-bus status bundle for pulse_program_sequencer.
interface pulse_program_sequencer_if;
   logic        cfg_wr;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_dur;
   logic [7:0]  cfg_pattern;
   logic [1:0]  cfg_trig;
   logic [3:0]  cfg_last_step;
   logic [15:0] cfg_repeat;
   logic        commit;
   logic        start;
   logic        stop;
   logic [7:0]  signal_out;
   logic        trigger;
   logic        verify_trigger;
   logic        busy;
   logic        done;
   logic [3:0]  step_index;
   logic        commit_pending;

   modport master (
      output cfg_wr, cfg_addr, cfg_dur, cfg_pattern, cfg_trig,
      output cfg_last_step, cfg_repeat, commit, start, stop,
      input  signal_out, trigger, verify_trigger, busy, done,
      input  step_index, commit_pending
   );

   modport slave (
      input  cfg_wr, cfg_addr, cfg_dur, cfg_pattern, cfg_trig,
      input  cfg_last_step, cfg_repeat, commit, start, stop,
      output signal_out, trigger, verify_trigger, busy, done,
      output step_index, commit_pending
   );
endinterface

// File: rtl/pulse_program_sequencer.sv
// 16-step pulse pattern sequencer with shadow/active tables that swap
// only between repetitions, so a running repetition never glitches.
module pulse_program_sequencer #(
   parameter int DUR_W = 22
) (
   input  logic clk_in,
   input  logic rst_in,
   pulse_program_sequencer_if.slave host
);
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   logic [DUR_W-1:0] sh_dur_q [16];
   logic [DUR_W-1:0] sh_dur_d [16];
   logic [7:0]       sh_pat_q [16];
   logic [7:0]       sh_pat_d [16];
   logic [1:0]       sh_trig_q [16];
   logic [1:0]       sh_trig_d [16];
   logic [3:0]       sh_last_q, sh_last_d;
   logic [15:0]      sh_rep_q, sh_rep_d;

   logic [DUR_W-1:0] act_dur_q [16];
   logic [DUR_W-1:0] act_dur_d [16];
   logic [7:0]       act_pat_q [16];
   logic [7:0]       act_pat_d [16];
   logic [1:0]       act_trig_q [16];
   logic [1:0]       act_trig_d [16];
   logic [3:0]       act_last_q, act_last_d;
   logic [15:0]      act_rep_q, act_rep_d;

   state_t           state_q;
   logic [3:0]       step_q;
   logic [DUR_W-1:0] tmr_q;
   logic [15:0]      rep_q;
   logic             pend_q;
   logic [7:0]       sig_q;
   logic             trig_q, vtrig_q, busy_q, done_q;

   logic        step_end, at_last, more_reps, pend_eff, apply;
   logic [16:0] rep_inc;
   logic [3:0]  nstep;
   logic        unused_dur;

   assign unused_dur = ^host.cfg_dur[31:DUR_W];

   // Timer counts down from D-1 so a zero duration still lasts one cycle.
   function automatic logic [DUR_W-1:0] ld(input logic [DUR_W-1:0] d);
      return (d == '0) ? '0 : d - DUR_W'(1);
   endfunction

   always_comb begin
      sh_dur_d  = sh_dur_q;
      sh_pat_d  = sh_pat_q;
      sh_trig_d = sh_trig_q;
      if (host.cfg_wr) begin
         sh_dur_d[host.cfg_addr]  = host.cfg_dur[DUR_W-1:0];
         sh_pat_d[host.cfg_addr]  = host.cfg_pattern;
         sh_trig_d[host.cfg_addr] = host.cfg_trig;
      end
      sh_last_d = host.commit ? host.cfg_last_step : sh_last_q;
      sh_rep_d  = host.commit ? host.cfg_repeat : sh_rep_q;
   end

   assign step_end  = (state_q == RUN) && (tmr_q == '0);
   assign at_last   = (step_q == act_last_q);
   assign rep_inc   = {1'b0, rep_q} + 17'd1;
   assign more_reps = (act_rep_q == '0) || (rep_inc < {1'b0, act_rep_q});
   assign pend_eff  = pend_q | host.commit;
   assign apply     = pend_eff && ((state_q != RUN) ||
                      (!host.stop && step_end && at_last && more_reps));
   assign nstep     = (state_q == RUN && !at_last) ? step_q + 4'd1 : 4'd0;

   always_comb begin
      act_dur_d  = act_dur_q;
      act_pat_d  = act_pat_q;
      act_trig_d = act_trig_q;
      act_last_d = act_last_q;
      act_rep_d  = act_rep_q;
      if (apply) begin
         act_dur_d  = sh_dur_d;
         act_pat_d  = sh_pat_d;
         act_trig_d = sh_trig_d;
         act_last_d = sh_last_d;
         act_rep_d  = sh_rep_d;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sh_dur_q   <= '{default: '0};
         sh_pat_q   <= '{default: '0};
         sh_trig_q  <= '{default: '0};
         sh_last_q  <= '0;
         sh_rep_q   <= '0;
         act_dur_q  <= '{default: '0};
         act_pat_q  <= '{default: '0};
         act_trig_q <= '{default: '0};
         act_last_q <= '0;
         act_rep_q  <= '0;
      end else begin
         sh_dur_q   <= sh_dur_d;
         sh_pat_q   <= sh_pat_d;
         sh_trig_q  <= sh_trig_d;
         sh_last_q  <= sh_last_d;
         sh_rep_q   <= sh_rep_d;
         act_dur_q  <= act_dur_d;
         act_pat_q  <= act_pat_d;
         act_trig_q <= act_trig_d;
         act_last_q <= act_last_d;
         act_rep_q  <= act_rep_d;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         step_q  <= '0;
         tmr_q   <= '0;
         rep_q   <= '0;
         pend_q  <= 1'b0;
         sig_q   <= '0;
         trig_q  <= 1'b0;
         vtrig_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         trig_q  <= 1'b0;
         vtrig_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               pend_q <= 1'b0;
               sig_q  <= '0;
               busy_q <= 1'b0;
               step_q <= '0;
               if (host.start && !host.stop) begin
                  state_q <= RUN;
                  rep_q   <= '0;
                  busy_q  <= 1'b1;
                  step_q  <= nstep;
                  tmr_q   <= ld(act_dur_d[nstep]);
                  sig_q   <= act_pat_d[nstep];
                  trig_q  <= act_trig_d[nstep][0];
                  vtrig_q <= act_trig_d[nstep][1];
               end
            end
            RUN: begin
               if (host.stop) begin
                  state_q <= IDLE;
                  pend_q  <= pend_eff;
                  sig_q   <= '0;
                  busy_q  <= 1'b0;
                  step_q  <= '0;
               end else if (!step_end) begin
                  tmr_q  <= tmr_q - DUR_W'(1);
                  pend_q <= pend_eff;
               end else if (!at_last || more_reps) begin
                  if (at_last && rep_q != 16'hFFFF) rep_q <= rep_q + 16'd1;
                  pend_q  <= pend_eff & ~apply;
                  step_q  <= nstep;
                  tmr_q   <= ld(act_dur_d[nstep]);
                  sig_q   <= act_pat_d[nstep];
                  trig_q  <= act_trig_d[nstep][0];
                  vtrig_q <= act_trig_d[nstep][1];
               end else begin
                  state_q <= FINISH;
                  pend_q  <= pend_eff;
                  sig_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  step_q  <= '0;
               end
            end
            FINISH: begin
               state_q <= IDLE;
               pend_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign host.signal_out     = sig_q;
   assign host.trigger        = trig_q;
   assign host.verify_trigger = vtrig_q;
   assign host.busy           = busy_q;
   assign host.done           = done_q;
   assign host.step_index     = step_q;
   assign host.commit_pending = pend_q;
endmodule
